// File: rtl/hp_bytequad.sv
// hp_bytequad: host-to-parasite Tube register quad; R1/R2/R4 byte latches, R3 small FIFO with drain gating,
// plus registered parasite IRQ/NMI derived from channel availability.
module hp_bytequad #(
  parameter int DATA_W   = 8,
  parameter int R3_DEPTH = 2
) (
  input  logic              h_phi2,
  input  logic              h_rst_b,
  input  logic              h_we,
  input  logic [3:0]        h_selectData,
  input  logic [DATA_W-1:0] h_data,
  input  logic              p_rd,
  input  logic [3:0]        p_selectData,
  input  logic              one_byte_mode,
  input  logic              irq_en_r1,
  input  logic              irq_en_r4,
  input  logic              nmi_en_r3,
  output logic [DATA_W-1:0] p_data,
  output logic [3:0]        p_data_available,
  output logic [3:0]        h_full,
  output logic              p_irq_b,
  output logic              p_nmi_b
);
  localparam int CW = $clog2(R3_DEPTH + 1);
  logic [3:0] h_sel, p_sel, wr, rd;
  logic [2:0] lwr, lrd, full_q, full_d;
  logic [DATA_W-1:0] lat_q [3];
  logic [DATA_W-1:0] lat_d [3];
  logic [DATA_W-1:0] fifo_q [R3_DEPTH];
  logic [DATA_W-1:0] fifo_d [R3_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d, wr_idx;
  logic drain_q, drain_d, irq_b_q, irq_b_d, nmi_b_q, nmi_b_d;
  logic r3_full, push, pop;
  // Multi-bit selects collapse to their lowest set bit
  assign h_sel = h_selectData & (~h_selectData + 4'd1);
  assign p_sel = p_selectData & (~p_selectData + 4'd1);
  assign wr = {4{h_we}} & h_sel;
  assign rd = {4{p_rd}} & p_sel;
  assign lwr = {wr[3], wr[1], wr[0]};
  assign lrd = {rd[3], rd[1], rd[0]};
  assign r3_full = cnt_q >= (one_byte_mode ? CW'(1) : CW'(R3_DEPTH));
  assign p_data_available = {full_q[2], one_byte_mode ? (cnt_q != '0) : drain_q, full_q[1], full_q[0]};
  assign h_full = {full_q[2], r3_full, full_q[1], full_q[0]};
  assign push = wr[2] & ~r3_full;
  assign pop = rd[2] & p_data_available[2];
  assign p_data = p_sel[0] ? lat_q[0] : p_sel[1] ? lat_q[1] : p_sel[2] ? fifo_q[0] : p_sel[3] ? lat_q[2] : '0;
  assign p_irq_b = irq_b_q;
  assign p_nmi_b = nmi_b_q;
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      full_d[k] = lwr[k] | (full_q[k] & ~lrd[k]);
      lat_d[k] = (lwr[k] & (~full_q[k] | lrd[k])) ? h_data : lat_q[k];
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_idx = cnt_q - CW'(pop);
    // Popping the last byte leaves it at the head so p_data keeps showing it
    for (int i = 0; i < R3_DEPTH; i++)
      fifo_d[i] = (push && wr_idx == CW'(i)) ? h_data :
                  (pop && cnt_q > CW'(1)) ? fifo_q[(i + 1) % R3_DEPTH] : fifo_q[i];
    drain_d = one_byte_mode ? (cnt_d != '0) : (cnt_d == CW'(R3_DEPTH)) ? 1'b1 : (cnt_d == '0) ? 1'b0 : drain_q;
    irq_b_d = ~((irq_en_r1 & p_data_available[0]) | (irq_en_r4 & p_data_available[3]));
    nmi_b_d = ~(nmi_en_r3 & p_data_available[2]);
  end
  always_ff @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      lat_q <= '{default: '0};
      full_q <= '0;
      fifo_q <= '{default: '0};
      cnt_q <= '0;
      drain_q <= 1'b0;
      irq_b_q <= 1'b1;
      nmi_b_q <= 1'b1;
    end else begin
      lat_q <= lat_d;
      full_q <= full_d;
      fifo_q <= fifo_d;
      cnt_q <= cnt_d;
      drain_q <= drain_d;
      irq_b_q <= irq_b_d;
      nmi_b_q <= nmi_b_d;
    end
  end
endmodule

// File: tb/tb_hp_bytequad.sv
// tb_hp_bytequad: queue-based model of the H->P quad checked every negedge, plus directed literal checks.
module tb_hp_bytequad;
  logic h_phi2 = 0, h_rst_b = 0, h_we = 0, p_rd = 0;
  logic one_byte_mode = 0, irq_en_r1 = 0, irq_en_r4 = 0, nmi_en_r3 = 0;
  logic [3:0] h_selectData = 0, p_selectData = 0;
  logic [7:0] h_data = 0;
  logic [7:0] p_data;
  logic [3:0] p_data_available, h_full;
  logic p_irq_b, p_nmi_b;
  int checks = 0, errors = 0;

  always #5 h_phi2 = ~h_phi2;

  hp_bytequad #(.DATA_W(8), .R3_DEPTH(2)) dut (
    .h_phi2(h_phi2), .h_rst_b(h_rst_b), .h_we(h_we), .h_selectData(h_selectData), .h_data(h_data),
    .p_rd(p_rd), .p_selectData(p_selectData), .one_byte_mode(one_byte_mode),
    .irq_en_r1(irq_en_r1), .irq_en_r4(irq_en_r4), .nmi_en_r3(nmi_en_r3),
    .p_data(p_data), .p_data_available(p_data_available), .h_full(h_full),
    .p_irq_b(p_irq_b), .p_nmi_b(p_nmi_b));

  logic [7:0] m_lat [4];
  bit m_full [4];
  logic [7:0] q [$];
  bit m_drain = 0, m_irq_b = 1, m_nmi_b = 1;
  logic [7:0] m_last = 0;
  logic [3:0] av_s, hf_s;
  int hs_s, ps_s, rdc_s;

  function automatic int low(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return -1;
  endfunction
  function automatic logic [3:0] m_av();
    return {m_full[3], one_byte_mode ? (q.size() != 0) : m_drain, m_full[1], m_full[0]};
  endfunction
  function automatic logic [3:0] m_hf();
    return {m_full[3], q.size() >= (one_byte_mode ? 1 : 2), m_full[1], m_full[0]};
  endfunction
  function automatic logic [7:0] m_pd();
    int ps;
    ps = low(p_selectData);
    if (ps < 0) return 8'h00;
    if (ps == 2) return (q.size() != 0) ? q[0] : m_last;
    return m_lat[ps];
  endfunction

  always @(posedge h_phi2 or negedge h_rst_b) begin
    if (!h_rst_b) begin
      m_lat = '{default: 8'h00};
      m_full = '{default: 1'b0};
      q.delete();
      m_drain = 0; m_last = 0; m_irq_b = 1; m_nmi_b = 1;
    end else begin
      av_s = m_av(); hf_s = m_hf();
      m_irq_b = ~((irq_en_r1 & av_s[0]) | (irq_en_r4 & av_s[3]));
      m_nmi_b = ~(nmi_en_r3 & av_s[2]);
      hs_s = low(h_selectData); ps_s = low(p_selectData);
      rdc_s = (p_rd && ps_s >= 0 && av_s[ps_s]) ? ps_s : -1;
      if (rdc_s == 2) m_last = q.pop_front();
      else if (rdc_s >= 0) m_full[rdc_s] = 0;
      if (h_we && hs_s >= 0) begin
        if (hs_s == 2) begin
          if (!hf_s[2]) q.push_back(h_data);
        end else if (!hf_s[hs_s] || rdc_s == hs_s) begin
          m_lat[hs_s] = h_data; m_full[hs_s] = 1;
        end
      end
      if (one_byte_mode) m_drain = q.size() != 0;
      else if (q.size() == 2) m_drain = 1;
      else if (q.size() == 0) m_drain = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge h_phi2); #1;
  endtask
  task automatic wr(input logic [3:0] s, input logic [7:0] d);
    h_we = 1; h_selectData = s; h_data = d; tick(); h_we = 0;
  endtask
  task automatic rd(input logic [3:0] s);
    p_rd = 1; p_selectData = s; tick(); p_rd = 0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge h_phi2);
        chk("model_avail", p_data_available, m_av());
        chk("model_h_full", h_full, m_hf());
        chk("model_p_data", p_data, m_pd());
        chk("model_irq", p_irq_b, m_irq_b);
        chk("model_nmi", p_nmi_b, m_nmi_b);
      end
    join_none
    irq_en_r1 = 1;
    tick(); tick(); h_rst_b = 1; tick();
    chk("rst_avail", p_data_available, 4'h0);
    chk("rst_full", h_full, 4'h0);
    chk("rst_irq", p_irq_b, 1);
    chk("rst_nmi", p_nmi_b, 1);
    chk("rst_pdata", p_data, 8'h00);
    // R1 + IRQ
    wr(4'b0001, 8'hA5);
    chk("r1_avail", p_data_available, 4'b0001);
    chk("r1_full", h_full, 4'b0001);
    chk("r1_irq_lag", p_irq_b, 1);
    tick();
    chk("r1_irq", p_irq_b, 0);
    p_selectData = 4'b0001; #1;
    chk("r1_data", p_data, 8'hA5);
    rd(4'b0001);
    chk("r1_avail_clr", p_data_available, 4'b0000);
    chk("r1_hold", p_data, 8'hA5);
    tick();
    chk("r1_irq_clr", p_irq_b, 1);
    // R2 drop and same-edge replace
    wr(4'b0010, 8'h11); wr(4'b0010, 8'h22);
    p_selectData = 4'b0010; #1;
    chk("r2_drop", p_data, 8'h11);
    h_we = 1; h_selectData = 4'b0010; h_data = 8'h33; p_rd = 1; tick(); h_we = 0; p_rd = 0;
    chk("r2_swap", p_data, 8'h33);
    chk("r2_full", h_full[1], 1);
    rd(4'b0010);
    chk("r2_empty", h_full[1], 0);
    // R3 two-byte mode
    nmi_en_r3 = 1;
    wr(4'b0100, 8'h01);
    chk("r3_one_avail", p_data_available[2], 0);
    chk("r3_one_full", h_full[2], 0);
    wr(4'b0100, 8'h02);
    chk("r3_two_avail", p_data_available[2], 1);
    chk("r3_two_full", h_full[2], 1);
    tick();
    chk("r3_nmi", p_nmi_b, 0);
    p_selectData = 4'b0100; #1;
    chk("r3_head0", p_data, 8'h01);
    rd(4'b0100);
    chk("r3_head1", p_data, 8'h02);
    chk("r3_drain", p_data_available[2], 1);
    rd(4'b0100);
    chk("r3_empty", p_data_available[2], 0);
    chk("r3_last", p_data, 8'h02);
    // push+pop at count 1 while draining
    wr(4'b0100, 8'h0A); wr(4'b0100, 8'h0B); rd(4'b0100);
    h_we = 1; h_selectData = 4'b0100; h_data = 8'h0C; p_rd = 1; tick(); h_we = 0; p_rd = 0;
    chk("r3_pp_head", p_data, 8'h0C);
    chk("r3_pp_avail", p_data_available[2], 1);
    rd(4'b0100);
    chk("r3_pp_empty", p_data_available[2], 0);
    // one-byte mode
    one_byte_mode = 1;
    wr(4'b0100, 8'h7E);
    chk("obm_avail", p_data_available[2], 1);
    chk("obm_full", h_full[2], 1);
    wr(4'b0100, 8'h55);
    chk("obm_drop", p_data, 8'h7E);
    rd(4'b0100);
    chk("obm_empty", p_data_available[2], 0);
    chk("obm_last", p_data, 8'h7E);
    // mode switch with one byte held
    one_byte_mode = 0;
    wr(4'b0100, 8'h9C);
    chk("sw_before", p_data_available[2], 0);
    one_byte_mode = 1; #1;
    chk("sw_avail", p_data_available[2], 1);
    chk("sw_full", h_full[2], 1);
    chk("sw_data", p_data, 8'h9C);
    tick(); one_byte_mode = 0; #1;
    chk("sw_back_drain", p_data_available[2], 1);
    chk("sw_back_full", h_full[2], 0);
    rd(4'b0100);
    chk("sw_empty", p_data_available[2], 0);
    // lowest-bit select
    wr(4'b1010, 8'h5A);
    chk("sel_low_full", h_full, 4'b0010);
    p_selectData = 4'b1110; #1;
    chk("sel_low_data", p_data, 8'h5A);
    rd(4'b1010);
    // mid-transfer reset
    irq_en_r4 = 1;
    wr(4'b0001, 8'hC1); wr(4'b1000, 8'hC4); wr(4'b0100, 8'hC2); wr(4'b0100, 8'hC3);
    tick();
    chk("pre_rst_avail", p_data_available, 4'b1101);
    chk("pre_rst_irq", p_irq_b, 0);
    chk("pre_rst_nmi", p_nmi_b, 0);
    #2 h_rst_b = 0; #1;
    chk("mid_rst_avail", p_data_available, 4'h0);
    chk("mid_rst_full", h_full, 4'h0);
    chk("mid_rst_irq", p_irq_b, 1);
    chk("mid_rst_nmi", p_nmi_b, 1);
    tick(); h_rst_b = 1;
    tick(); tick();
    chk("post_rst_avail", p_data_available, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
